// File: rtl/seventeen_bit_adder_reg_pkg.sv
// Shared constants and types for the registered 17-bit ripple adder.
`default_nettype none

package seventeen_bit_adder_reg_pkg;

  localparam int ADDER_WIDTH  = 17;
  localparam int RESULT_WIDTH = ADDER_WIDTH + 1;

  // Full exact result of a + b + c_in: carry-out on top of the sum.
  typedef struct packed {
    logic                   c_out;
    logic [ADDER_WIDTH-1:0] sum;
  } adder_result_t;

endpackage

`default_nettype wire

// File: rtl/seventeen_bit_adder_reg_if.sv
// Operand/result bundle between the adder and its producer/consumer.
`default_nettype none

interface seventeen_bit_adder_reg_if
  import seventeen_bit_adder_reg_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             out_valid;

  modport master (
    output in_valid, a, b, c_in,
    input  sum, c_out, out_valid
  );

  modport slave (
    input  in_valid, a, b, c_in,
    output sum, c_out, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/seventeen_bit_adder_reg_full_adder_cell.sv
// One-bit full adder: the repeated cell of the ripple chain.
`default_nettype none

module full_adder_cell (
  input  wire logic x,
  input  wire logic y,
  input  wire logic ci,
  output logic      s,
  output logic      co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

`default_nettype wire

// File: rtl/seventeen_bit_adder_reg.sv
// Ripple-carry adder with a one-cycle registered result and travelling valid flag.
`default_nettype none

module seventeen_bit_adder_reg
  import seventeen_bit_adder_reg_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  seventeen_bit_adder_reg_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             valid_q;

  assign carry[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .x  (bus.a[i]),
      .y  (bus.b[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

  // Data only loads on valid so idle-cycle operand garbage never disturbs the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= sum_d;
        c_out_q <= carry[WIDTH];
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_seventeen_bit_adder_reg.sv
// Self-checking bench: arithmetic reference model, per-cycle compare, directed literal checks.
`default_nettype none

module tb_seventeen_bit_adder_reg;
  import seventeen_bit_adder_reg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic cmp_en = 1'b0;

  seventeen_bit_adder_reg_if #(.WIDTH(ADDER_WIDTH)) bus ();

  seventeen_bit_adder_reg #(.WIDTH(ADDER_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: result register holds the exact 18-bit sum of the last valid operands.
  logic [RESULT_WIDTH-1:0] m_res;
  logic                    m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res   <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= bus.in_valid;
      if (bus.in_valid)
        m_res <= RESULT_WIDTH'(bus.a) + RESULT_WIDTH'(bus.b) + RESULT_WIDTH'(bus.c_in);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if ({bus.c_out, bus.sum} !== m_res || bus.out_valid !== m_valid) begin
        n_errors++;
        $display("FAIL cycle t=%0t got res=%05h v=%b want res=%05h v=%b",
                 $time, {bus.c_out, bus.sum}, bus.out_valid, m_res, m_valid);
      end
    end
  end

  task automatic check_lit(input string name, input logic [RESULT_WIDTH-1:0] res,
                           input logic vld);
    adder_result_t got;
    got = '{c_out: bus.c_out, sum: bus.sum};
    n_checks++;
    if (got !== res || bus.out_valid !== vld) begin
      n_errors++;
      $display("FAIL %s got res=%05h v=%b want res=%05h v=%b",
               name, got, bus.out_valid, res, vld);
    end
    n_checks++;
    if (m_res !== res || m_valid !== vld) begin
      n_errors++;
      $display("FAIL %s_model got res=%05h v=%b want res=%05h v=%b",
               name, m_res, m_valid, res, vld);
    end
  endtask

  // Called at a falling edge: drive operands, advance to the next falling edge.
  task automatic step(input logic iv, input logic [16:0] a, input logic [16:0] b,
                      input logic ci);
    bus.in_valid = iv;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c_in     = 1'b0;
    #1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check_lit("reset", 18'h00000, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 17'h0, 17'h0, 1'b0);
    step(1'b0, 17'h0, 17'h0, 1'b0);
    check_lit("post_reset_idle", 18'h00000, 1'b0);

    step(1'b1, 17'h00000, 17'h00000, 1'b0);
    check_lit("zero", 18'h00000, 1'b1);
    step(1'b1, 17'h00000, 17'h00000, 1'b1);
    check_lit("cin_only", 18'h00001, 1'b1);
    step(1'b1, 17'h1FFFF, 17'h00000, 1'b1);
    check_lit("ripple_wrap", 18'h20000, 1'b1);
    step(1'b1, 17'h1FFFF, 17'h1FFFF, 1'b1);
    check_lit("all_ones", 18'h3FFFF, 1'b1);
    step(1'b1, 17'h10000, 17'h10000, 1'b0);
    check_lit("msb_carry", 18'h20000, 1'b1);
    step(1'b1, 17'd12345, 17'd54321, 1'b1);
    check_lit("decimal", 18'h1046B, 1'b1);

    step(1'b1, 17'd3, 17'd4, 1'b0);
    check_lit("hold_load", 18'd7, 1'b1);
    step(1'b0, 17'h1FFFF, 17'h1FFFF, 1'b1);
    check_lit("hold_1", 18'd7, 1'b0);
    step(1'b0, 17'h1FFFF, 17'h1FFFF, 1'b1);
    check_lit("hold_2", 18'd7, 1'b0);

    step(1'b1, 17'd1000, 17'd1, 1'b1);
    check_lit("b2b_0", 18'd1002, 1'b1);
    step(1'b1, 17'd2000, 17'd2, 1'b0);
    check_lit("b2b_1", 18'd2002, 1'b1);
    step(1'b1, 17'h1FFFE, 17'd3, 1'b0);
    check_lit("b2b_2", 18'h20001, 1'b1);

    // Mid-stream asynchronous reset with a fresh capture in flight.
    bus.in_valid = 1'b1;
    bus.a        = 17'd100;
    bus.b        = 17'd200;
    bus.c_in     = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("async_reset", 18'h00000, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 17'h1FFFF, 17'h1FFFF, 1'b1);
    check_lit("after_reset_idle", 18'h00000, 1'b0);
    step(1'b1, 17'd1, 17'd1, 1'b0);
    check_lit("after_reset_load", 18'd2, 1'b1);

    for (int i = 0; i < 3000; i++)
      step(1'b1, 17'($urandom_range(131071)), 17'($urandom_range(131071)),
           1'($urandom_range(1)));
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(1)), 17'($urandom_range(131071)),
           17'($urandom_range(131071)), 1'($urandom_range(1)));

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
